// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, frame size, register address map and sequencer FSM states.
package spi_pkg;

  localparam int BYTE_SIZE = 8;

  localparam logic [7:0] OP_READ      = 8'h00;
  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_CLK_DIV   = 8'h05;
  localparam logic [7:0] OP_WRITE_MEM = 8'h07;
  localparam logic [7:0] OP_DEBUG_CFG = 8'h09;

  localparam logic [7:0] ADDR_SPIKES_LO  = 8'h00;
  localparam logic [7:0] ADDR_SPIKES_HI  = 8'h02;
  localparam logic [7:0] ADDR_DECAY      = 8'h03;
  localparam logic [7:0] ADDR_REFRACTORY = 8'h04;
  localparam logic [7:0] ADDR_THRESHOLD  = 8'h05;
  localparam logic [7:0] ADDR_DIV        = 8'h06;
  localparam logic [7:0] ADDR_WEIGHTS_LO = 8'h07;
  localparam logic [7:0] ADDR_WEIGHTS_HI = 8'h3A;
  localparam logic [7:0] ADDR_DELAYS_LO  = 8'h3B;
  localparam logic [7:0] ADDR_DELAYS_HI  = 8'hA2;
  localparam logic [7:0] ADDR_DEBUG      = 8'hA3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/spi_byte_txrx.sv
// One-byte serialiser: parallel-load MOSI shifter, MISO capture shifter and frame bit counter.
module spi_byte_txrx #(
  parameter int BYTE_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [BYTE_SIZE-1:0] i_load_byte,
  input  logic                 i_shift,
  input  logic                 i_capture,
  input  logic                 i_miso,
  output logic                 o_mosi,
  output logic                 o_last_bit,
  output logic [BYTE_SIZE-1:0] o_rx_byte
);

  localparam int CNT_W = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;

  logic [BYTE_SIZE-1:0] r_tx;
  logic [BYTE_SIZE-1:0] r_rx;
  logic [CNT_W-1:0]     r_bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_load) begin
        r_tx      <= i_load_byte;
        r_bit_cnt <= '0;
      end else if (i_shift) begin
        r_tx      <= {r_tx[BYTE_SIZE-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      // Capture only during the data frame so rsp_data holds between commands
      if (i_shift && i_capture)
        r_rx <= {r_rx[BYTE_SIZE-2:0], i_miso};
    end
  end

  assign o_mosi     = r_tx[BYTE_SIZE-1];
  assign o_last_bit = (r_bit_cnt == CNT_W'(BYTE_SIZE - 1));
  assign o_rx_byte  = r_rx;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: sends {addr_msb, addr_lsb, instr, data} as four SS-framed bytes
// and returns the byte captured on MISO during the data frame.
module spi_cmd_sequencer #(
  parameter int BYTE_GAP  = 3,
  parameter int BYTE_SIZE = spi_pkg::BYTE_SIZE
) (
  input  logic        SCLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_instr,
  input  logic [7:0]  cmd_data,
  output logic        MOSI,
  output logic        SS,
  input  logic        MISO,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  import spi_pkg::*;

  if (BYTE_SIZE != 8 || BYTE_GAP < 1 || BYTE_GAP > 15) begin : g_param_check
    $error("spi_cmd_sequencer: BYTE_SIZE must be 8 and BYTE_GAP must be 1..15");
  end

  seq_state_e  r_state;
  seq_state_e  w_next_state;
  logic [1:0]  r_byte_idx;
  logic [3:0]  r_gap_cnt;
  logic [31:0] r_buf;
  logic        r_mosi;
  logic        r_ss;

  logic        w_accept;
  logic        w_gap_last;
  logic        w_last_bit;
  logic        w_tx_bit;
  logic        w_load;
  logic        w_shift;
  logic        w_capture;
  logic        w_ss;
  logic        w_mosi;
  logic [7:0]  w_cur_byte;
  logic [7:0]  w_rx_byte;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_gap_last = (r_gap_cnt == 4'(BYTE_GAP - 1));
  assign w_capture  = (r_byte_idx == 2'd3);

  always_comb begin
    w_cur_byte = r_buf[31:24];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_buf[31:24];
      2'd1:    w_cur_byte = r_buf[23:16];
      2'd2:    w_cur_byte = r_buf[15:8];
      default: w_cur_byte = r_buf[7:0];
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)   w_next_state = ST_GAP;
      ST_GAP:   if (w_gap_last) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last_bit) w_next_state = (r_byte_idx == 2'd3) ? ST_DONE : ST_GAP;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    w_ss      = 1'b1;
    w_mosi    = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !RESET;
        busy      = 1'b0;
      end
      ST_GAP:   w_load = w_gap_last;
      ST_SHIFT: begin
        w_ss    = 1'b0;
        w_mosi  = w_tx_bit;
        w_shift = 1'b1;
      end
      ST_DONE:  rsp_valid = !RESET;
      default:  busy = 1'b1;
    endcase
  end

  // Command bytes are latched once at acceptance; later input changes are ignored
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      r_buf      <= '0;
      r_byte_idx <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_buf      <= {cmd_addr, cmd_instr, cmd_data};
          r_byte_idx <= 2'd0;
          r_gap_cnt  <= 4'd0;
        end
        ST_GAP:   r_gap_cnt <= w_gap_last ? 4'd0 : r_gap_cnt + 4'd1;
        ST_SHIFT: if (w_last_bit && r_byte_idx != 2'd3) r_byte_idx <= r_byte_idx + 2'd1;
        default:  r_gap_cnt <= 4'd0;
      endcase
    end
  end

  // Half-cycle retime so the downstream rising-edge sampler sees settled levels
  always_ff @(negedge SCLK) begin
    if (RESET) begin
      r_ss   <= 1'b1;
      r_mosi <= 1'b0;
    end else begin
      r_ss   <= w_ss;
      r_mosi <= w_mosi;
    end
  end

  assign SS   = r_ss;
  assign MOSI = r_mosi;

  spi_byte_txrx #(
    .BYTE_SIZE (BYTE_SIZE)
  ) u_txrx (
    .clk         (SCLK),
    .rst         (RESET),
    .i_load      (w_load),
    .i_load_byte (w_cur_byte),
    .i_shift     (w_shift),
    .i_capture   (w_capture),
    .i_miso      (MISO),
    .o_mosi      (w_tx_bit),
    .o_last_bit  (w_last_bit),
    .o_rx_byte   (w_rx_byte)
  );

  assign rsp_data = w_rx_byte;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: decodes the SS/MOSI frames, models MISO for the data frame.
module tb_spi_cmd_sequencer;

  localparam int EXP_GAP     = 3;
  localparam int EXP_SIZE    = 8;
  localparam int EXP_LATENCY = 4 * (EXP_GAP + EXP_SIZE) + 1;

  logic        SCLK;
  logic        RESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_instr;
  logic [7:0]  cmd_data;
  logic        MOSI;
  logic        SS;
  logic        MISO;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  int n_cmp;
  int n_err;

  logic [7:0] rx_bytes [4];
  int         frame_len[4];
  int         gap_len  [4];
  int         nframes;
  int         latency;
  int         acc_wait;
  logic [7:0] miso_pat;

  spi_cmd_sequencer dut (
    .SCLK      (SCLK),
    .RESET     (RESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_instr (cmd_instr),
    .cmd_data  (cmd_data),
    .MOSI      (MOSI),
    .SS        (SS),
    .MISO      (MISO),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for an IDLE cycle, presents the command, and returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] i, input logic [7:0] d,
                       input bit hold);
    bit ok;
    ok = 1'b0;
    acc_wait = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge SCLK); #1;
      if (cmd_ready) begin
        cmd_addr  = a;
        cmd_instr = i;
        cmd_data  = d;
        cmd_valid = 1'b1;
        acc_wait  = k;
        ok        = 1'b1;
        break;
      end
    end
    chk("accept_seen", {31'd0, ok}, 32'd1);
    @(posedge SCLK); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Called right after the accepting edge; runs until rsp_valid or the budget expires.
  task automatic collect(input int budget, input bit inject);
    int gap_run;
    int bitpos;
    bit prev_ss;
    gap_run = 0;
    bitpos  = 0;
    prev_ss = 1'b1;
    nframes = 0;
    latency = -1;
    for (int b = 0; b < 4; b++) begin
      rx_bytes[b]  = 8'h00;
      frame_len[b] = 0;
      gap_len[b]   = 0;
    end
    for (int n = 1; n <= budget; n++) begin
      @(negedge SCLK); #1;
      if (inject && n == 16) begin
        cmd_addr  = 16'hFFFF;
        cmd_instr = 8'hFF;
        cmd_data  = 8'hFF;
        cmd_valid = 1'b1;
        chk("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
      end
      if (inject && n == 17) cmd_valid = 1'b0;
      if (!SS) begin
        if (prev_ss) begin
          if (nframes < 4) gap_len[nframes] = gap_run;
          nframes++;
          bitpos = 0;
        end
        if (nframes >= 1 && nframes <= 4) begin
          rx_bytes[nframes-1]  = {rx_bytes[nframes-1][6:0], MOSI};
          frame_len[nframes-1] = frame_len[nframes-1] + 1;
        end
        MISO = (nframes == 4 && bitpos < 8) ? miso_pat[7-bitpos] : 1'b0;
        bitpos++;
        gap_run = 0;
      end else begin
        gap_run++;
        MISO = 1'b0;
      end
      prev_ss = SS;
      if (rsp_valid) begin
        latency = n;
        break;
      end
    end
  endtask

  task automatic check_cmd(input string tag, input logic [15:0] a, input logic [7:0] i,
                           input logic [7:0] d);
    logic [7:0] exp_b[4];
    exp_b[0] = a[15:8];
    exp_b[1] = a[7:0];
    exp_b[2] = i;
    exp_b[3] = d;
    chk($sformatf("%s_latency", tag), latency, EXP_LATENCY);
    chk($sformatf("%s_frames", tag), nframes, 4);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_byte%0d", tag, b), {24'd0, rx_bytes[b]}, {24'd0, exp_b[b]});
      chk($sformatf("%s_len%0d", tag, b), frame_len[b], EXP_SIZE);
      chk($sformatf("%s_gap%0d", tag, b), gap_len[b], EXP_GAP);
    end
    chk($sformatf("%s_rsp_data", tag), {24'd0, rsp_data}, {24'd0, miso_pat});
  endtask

  initial begin
    int hits;
    logic [23:0] spikes;
    n_cmp     = 0;
    n_err     = 0;
    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 16'h0000;
    cmd_instr = 8'h00;
    cmd_data  = 8'h00;
    MISO      = 1'b0;
    miso_pat  = 8'h00;

    // Reset state
    repeat (3) @(posedge SCLK);
    @(negedge SCLK); #1;
    chk("rst_ss", {31'd0, SS}, 32'd1);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    RESET = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Plain write
    miso_pat = 8'h00;
    issue(16'h1234, 8'h01, 8'hA5, 1'b0);
    collect(80, 1'b0);
    check_cmd("wr", 16'h1234, 8'h01, 8'hA5);
    @(negedge SCLK); #1;
    chk("wr_pulse_1cyc", {31'd0, rsp_valid}, 32'd0);
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    chk("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Read with MISO returning 0x5A in the data frame
    miso_pat = 8'h5A;
    issue(16'h4534, 8'h00, 8'h00, 1'b0);
    collect(80, 1'b0);
    check_cmd("rd", 16'h4534, 8'h00, 8'h00);
    repeat (3) @(negedge SCLK);
    #1;
    chk("rd_rsp_hold", {24'd0, rsp_data}, 32'h5A);

    // Back-to-back with cmd_valid held; inputs switch to the next command right after acceptance
    miso_pat = 8'h3C;
    issue(16'h1306, 8'h05, 8'hB6, 1'b1);
    cmd_addr  = 16'h07A3;
    cmd_instr = 8'h09;
    cmd_data  = 8'hD8;
    collect(80, 1'b0);
    check_cmd("b2b_a", 16'h1306, 8'h05, 8'hB6);
    miso_pat = 8'hC3;
    issue(16'h07A3, 8'h09, 8'hD8, 1'b0);
    chk("b2b_accept_first_idle", acc_wait, 0);
    collect(80, 1'b0);
    check_cmd("b2b_b", 16'h07A3, 8'h09, 8'hD8);

    // cmd_valid pulse with all-ones data while busy in byte 1
    miso_pat = 8'h96;
    issue(16'h0A0B, 8'h01, 8'h3C, 1'b0);
    collect(80, 1'b1);
    check_cmd("busy_ign", 16'h0A0B, 8'h01, 8'h3C);

    // Reset asserted during bit 4 of byte 2
    issue(16'h1122, 8'h01, 8'h33, 1'b0);
    repeat (30) @(negedge SCLK);
    #1;
    chk("mid_ss_low", {31'd0, SS}, 32'd0);
    RESET = 1'b1;
    @(posedge SCLK); #1;
    @(negedge SCLK); #1;
    chk("abort_ss", {31'd0, SS}, 32'd1);
    chk("abort_mosi", {31'd0, MOSI}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rsp_data", {24'd0, rsp_data}, 32'h00);
    RESET = 1'b0;
    #1;
    chk("abort_ready_release", {31'd0, cmd_ready}, 32'd1);
    hits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge SCLK); #1;
      if (rsp_valid || !SS) hits++;
    end
    chk("abort_no_rsp", hits, 0);
    miso_pat = 8'h81;
    issue(16'h2468, 8'h01, 8'h7E, 1'b0);
    collect(80, 1'b0);
    check_cmd("post_abort", 16'h2468, 8'h01, 8'h7E);

    // Spike bytes 0xFEDCBA to addresses 0x00-0x02, LSB byte first
    spikes   = 24'hFEDCBA;
    miso_pat = 8'h00;
    for (int j = 0; j < 3; j++) begin
      issue({8'h00, 8'(j)}, 8'h07, spikes[8*j +: 8], 1'b0);
      collect(80, 1'b0);
      check_cmd($sformatf("spk%0d", j), {8'h00, 8'(j)}, 8'h07, spikes[8*j +: 8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
